// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared types and 3x3 kernel coefficient tables for the
//               convolution frame controller.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    typedef enum logic [1:0] {
        SEL_BOX      = 2'd0,
        SEL_SHARPEN  = 2'd1,
        SEL_EDGE     = 2'd2,
        SEL_IDENTITY = 2'd3
    } kernel_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } ctrl_state_e;

    typedef int coef3x3_t [3][3];

    localparam coef3x3_t C_KERNEL_BOX      = '{'{ 1,  1,  1}, '{ 1,  1,  1}, '{ 1,  1,  1}};
    localparam coef3x3_t C_KERNEL_SHARPEN  = '{'{ 0, -1,  0}, '{-1,  5, -1}, '{ 0, -1,  0}};
    localparam coef3x3_t C_KERNEL_EDGE     = '{'{-1, -1, -1}, '{-1,  8, -1}, '{-1, -1, -1}};
    localparam coef3x3_t C_KERNEL_IDENTITY = '{'{ 0,  0,  0}, '{ 0,  1,  0}, '{ 0,  0,  0}};

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_kernel_rom.sv
`default_nettype none
// ============================================================================
// Module      : conv_kernel_rom
// Description : Combinational kernel-select to 3x3 coefficient lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_kernel_rom
    import conv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [1:0]          i_sel,
    output logic signed [W-1:0] o_coef [3][3]
);

    coef3x3_t w_tbl;

    always_comb begin
        w_tbl = C_KERNEL_BOX;
        case (kernel_sel_e'(i_sel))
            SEL_BOX:      w_tbl = C_KERNEL_BOX;
            SEL_SHARPEN:  w_tbl = C_KERNEL_SHARPEN;
            SEL_EDGE:     w_tbl = C_KERNEL_EDGE;
            SEL_IDENTITY: w_tbl = C_KERNEL_IDENTITY;
            default:      w_tbl = C_KERNEL_BOX;
        endcase
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                o_coef[r][c] = W'(w_tbl[r][c]);
            end
        end
    end

endmodule : conv_kernel_rom
`default_nettype wire

// File: rtl/conv_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : conv_frame_controller
// Description : Frame sequencer around a 3x3 convolution filter: loads the
//               kernel, gates N pixels in and N results out, detects drain
//               stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_frame_controller
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480,
    parameter int W             = 8,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [1:0]                    cfg_sel,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [W-1:0]                  s_data,
    output logic                          f_x_valid,
    input  logic                          f_x_ready,
    output logic [W-1:0]                  f_x_data,
    input  logic                          f_y_valid,
    output logic                          f_y_ready,
    input  logic [W-1:0]                  f_y_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [W-1:0]                  m_data,
    output logic signed [W-1:0]           kernel [3][3],
    output logic [$clog2(IMG_WIDTH)-1:0]  in_col,
    output logic [$clog2(IMG_HEIGHT)-1:0] in_row,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          error
);

    localparam int C_NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int C_CNT_W = $clog2(C_NPIX + 1);
    localparam int C_COL_W = $clog2(IMG_WIDTH);
    localparam int C_ROW_W = $clog2(IMG_HEIGHT);
    localparam int C_TO_W  = $clog2(DRAIN_TIMEOUT);

    localparam logic [C_CNT_W-1:0] C_N_CNT    = C_CNT_W'(C_NPIX);
    localparam logic [C_CNT_W-1:0] C_N_LAST   = C_CNT_W'(C_NPIX - 1);
    localparam logic [C_COL_W-1:0] C_LAST_COL = C_COL_W'(IMG_WIDTH - 1);
    localparam logic [C_ROW_W-1:0] C_LAST_ROW = C_ROW_W'(IMG_HEIGHT - 1);
    localparam logic [C_TO_W-1:0]  C_TO_LAST  = C_TO_W'(DRAIN_TIMEOUT - 1);

    ctrl_state_e          r_state;
    ctrl_state_e          w_next;
    logic [C_CNT_W-1:0]   r_in_cnt;
    logic [C_CNT_W-1:0]   r_out_cnt;
    logic [C_TO_W-1:0]    r_drain_cnt;
    logic [C_COL_W-1:0]   r_in_col;
    logic [C_ROW_W-1:0]   r_in_row;
    logic [1:0]           r_pending_sel;
    logic signed [W-1:0]  r_kernel [3][3];
    logic signed [W-1:0]  w_rom_coef [3][3];
    logic                 r_error;

    logic w_in_open;
    logic w_out_open;
    logic w_in_hs;
    logic w_out_hs;
    logic w_timeout;
    logic w_clear;
    logic w_start_acc;

    conv_kernel_rom #(
        .W (W)
    ) u_kernel_rom (
        .i_sel  (r_pending_sel),
        .o_coef (w_rom_coef)
    );

    // Stream gating is purely combinational so the filter sees zero added latency.
    always_comb begin
        w_in_open  = (r_state == ST_STREAM) && (r_in_cnt != C_N_CNT);
        w_out_open = ((r_state == ST_STREAM) || (r_state == ST_DRAIN)) && (r_out_cnt != C_N_CNT);
        f_x_valid  = w_in_open && s_valid;
        s_ready    = w_in_open && f_x_ready;
        f_x_data   = s_data;
        m_valid    = w_out_open && f_y_valid;
        f_y_ready  = w_out_open && m_ready;
        m_data     = f_y_data;
        w_in_hs    = s_valid && s_ready;
        w_out_hs   = m_valid && m_ready;
        busy       = (r_state == ST_LOAD) || (r_state == ST_STREAM) || (r_state == ST_DRAIN);
        frame_done = (r_state == ST_DONE);
    end

    always_comb begin
        w_next      = r_state;
        w_timeout   = 1'b0;
        w_start_acc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next      = ST_LOAD;
                    w_start_acc = 1'b1;
                end
            end
            ST_LOAD: w_next = ST_STREAM;
            ST_STREAM: begin
                if (w_out_hs && (r_out_cnt == C_N_LAST)) begin
                    w_next = ST_DONE;
                end else if (w_in_hs && (r_in_cnt == C_N_LAST)) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_out_hs && (r_out_cnt == C_N_LAST)) begin
                    w_next = ST_DONE;
                end else if (!w_out_hs && (r_drain_cnt == C_TO_LAST)) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        // Abort outranks completion and timeout in the same cycle.
        if (abort && busy) begin
            w_next    = ST_IDLE;
            w_timeout = 1'b0;
        end
        w_clear = (r_state != ST_IDLE) && (w_next == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_in_cnt      <= '0;
            r_out_cnt     <= '0;
            r_drain_cnt   <= '0;
            r_in_col      <= '0;
            r_in_row      <= '0;
            r_pending_sel <= 2'(SEL_BOX);
            r_error       <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_kernel[r][c] <= W'(C_KERNEL_BOX[r][c]);
                end
            end
        end else begin
            r_state <= w_next;

            if (cfg_we) begin
                r_pending_sel <= cfg_sel;
            end

            if (r_state == ST_LOAD) begin
                r_kernel <= w_rom_coef;
            end

            if (w_start_acc) begin
                r_error <= 1'b0;
            end else if (w_timeout) begin
                r_error <= 1'b1;
            end

            if (w_clear) begin
                r_in_cnt <= '0;
                r_in_col <= '0;
                r_in_row <= '0;
            end else if (w_in_hs) begin
                r_in_cnt <= r_in_cnt + 1'b1;
                if (r_in_col == C_LAST_COL) begin
                    r_in_col <= '0;
                    r_in_row <= (r_in_row == C_LAST_ROW) ? '0 : r_in_row + 1'b1;
                end else begin
                    r_in_col <= r_in_col + 1'b1;
                end
            end

            if (w_clear) begin
                r_out_cnt <= '0;
            end else if (w_out_hs) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end

            if ((r_state != ST_DRAIN) || w_out_hs) begin
                r_drain_cnt <= '0;
            end else begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end
        end
    end

    assign kernel = r_kernel;
    assign in_col = r_in_col;
    assign in_row = r_in_row;
    assign error  = r_error;

endmodule : conv_frame_controller
`default_nettype wire

// File: tb/tb_conv_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_frame_controller
// Description : Self-checking bench: kernel table vectors, randomized frames
//               against an ordered-output reference, timeout/abort/reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_frame_controller;

    localparam int IW = 4;
    localparam int IH = 3;
    localparam int NP = IW * IH;
    localparam int TO = 8;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_we = 1'b0;
    logic [1:0] cfg_sel = 2'd0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic s_valid = 1'b0;
    logic s_ready;
    logic [W-1:0] s_data = '0;
    logic f_x_valid;
    logic f_x_ready = 1'b1;
    logic [W-1:0] f_x_data;
    logic f_y_valid = 1'b0;
    logic f_y_ready;
    logic [W-1:0] f_y_data = '0;
    logic m_valid;
    logic m_ready = 1'b1;
    logic [W-1:0] m_data;
    logic signed [W-1:0] kernel [3][3];
    logic [1:0] in_col;
    logic [1:0] in_row;
    logic busy;
    logic frame_done;
    logic error;

    conv_frame_controller #(
        .IMG_WIDTH     (IW),
        .IMG_HEIGHT    (IH),
        .W             (W),
        .DRAIN_TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .start      (start),
        .abort      (abort),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .f_x_valid  (f_x_valid),
        .f_x_ready  (f_x_ready),
        .f_x_data   (f_x_data),
        .f_y_valid  (f_y_valid),
        .f_y_ready  (f_y_ready),
        .f_y_data   (f_y_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .kernel     (kernel),
        .in_col     (in_col),
        .in_row     (in_row),
        .busy       (busy),
        .frame_done (frame_done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int m_hs     = 0;
    int done_cnt = 0;
    bit flt_hold  = 1'b0;
    bit flt_flush = 1'b0;
    bit m_rand    = 1'b0;

    logic [W-1:0] exp_q [$];
    logic [W-1:0] fq [$];

    typedef struct {
        logic [1:0] sel;
        int         k00;
        int         k01;
        int         k11;
    } kvec_t;
    kvec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Stand-in filter: one-plus cycle latency, output = pixel ^ 8'h5A, in order.
    always begin : p_filter
        logic          xhs;
        logic          yhs;
        logic [W-1:0]  xd;
        @(negedge clk);
        xhs = f_x_valid && f_x_ready;
        yhs = f_y_valid && f_y_ready;
        xd  = f_x_data;
        @(posedge clk);
        #1;
        if (rst || flt_flush) begin
            fq.delete();
        end else begin
            if (yhs) void'(fq.pop_front());
            if (xhs) fq.push_back(xd ^ 8'h5A);
        end
        f_x_ready = ($urandom_range(0, 3) != 0);
        f_y_valid = !flt_hold && (fq.size() > 0) && ($urandom_range(0, 2) != 0);
        f_y_data  = (fq.size() > 0) ? fq[0] : '0;
    end

    always begin : p_mready
        @(posedge clk);
        #1;
        m_ready = m_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    always @(negedge clk) begin : p_monitor
        logic [W-1:0] e;
        if (m_valid && m_ready) begin
            m_hs++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL m_unexpected: got data %0h required no handshake", m_data);
            end else begin
                e = exp_q.pop_front();
                chk("m_data", 32'(m_data), 32'(e));
            end
        end
        if (frame_done) begin
            done_cnt++;
            chk("busy_in_done", 32'(busy), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] sel);
        cfg_we  = 1'b1;
        cfg_sel = sel;
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic start_frame(input bit with_cfg, input logic [1:0] sel);
        if (with_cfg) begin
            cfg_we  = 1'b1;
            cfg_sel = sel;
        end
        start = 1'b1;
        tick();
        start  = 1'b0;
        cfg_we = 1'b0;
        chk("busy_load", 32'(busy), 1);
        chk("error_cleared_on_start", 32'(error), 0);
        tick();
    endtask

    task automatic send_pixels(input int n, input bit mid_cfg);
        int sent  = 0;
        int guard = 0;
        bit did   = 1'b0;
        while (sent < n && guard < 400) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = W'($urandom);
            if (mid_cfg && sent == 6 && !did) begin
                cfg_we  = 1'b1;
                cfg_sel = 2'd2;
                did     = 1'b1;
            end else begin
                cfg_we = 1'b0;
            end
            @(negedge clk);
            if (s_valid && s_ready) begin
                chk("in_col", 32'(in_col), 32'(sent % IW));
                chk("in_row", 32'(in_row), 32'(sent / IW));
                chk("fx_data", 32'(f_x_data), 32'(s_data));
                exp_q.push_back(s_data ^ 8'h5A);
                sent++;
            end
            tick();
            guard++;
        end
        s_valid = 1'b0;
        cfg_we  = 1'b0;
        if (sent < n) chk("send_timeout", 32'(sent), 32'(n));
    endtask

    task automatic wait_done(input int h0, input int d0);
        int i = 0;
        while (done_cnt == d0 && i < 300) begin
            tick();
            i++;
        end
        chk("frame_done_once", 32'(done_cnt - d0), 1);
        chk("m_handshakes", 32'(m_hs - h0), NP);
        chk("exp_q_empty", 32'(exp_q.size()), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_frame_done", 32'(frame_done), 0);
        chk("idle_col", 32'(in_col), 0);
        chk("idle_row", 32'(in_row), 0);
    endtask

    task automatic normal_frame(input int centre);
        int h0 = m_hs;
        int d0 = done_cnt;
        start_frame(1'b0, 2'd0);
        chk("normal_centre", 32'(kernel[1][1]), 32'(centre));
        send_pixels(NP, 1'b0);
        wait_done(h0, d0);
    endtask

    task automatic flush_filter();
        flt_flush = 1'b1;
        repeat (2) tick();
        flt_flush = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : p_main
        int h0;
        int d0;
        tbl[0] = '{sel: 2'd3, k00:  0, k01:  0, k11: 1};
        tbl[1] = '{sel: 2'd1, k00:  0, k01: -1, k11: 5};
        tbl[2] = '{sel: 2'd2, k00: -1, k01: -1, k11: 8};
        tbl[3] = '{sel: 2'd0, k00:  1, k01:  1, k11: 1};

        // Reset values
        repeat (3) tick();
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_f_x_valid", 32'(f_x_valid), 0);
        chk("rst_f_y_ready", 32'(f_y_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_k11", 32'(kernel[1][1]), 1);
        chk("rst_k00", 32'(kernel[0][0]), 1);
        chk("rst_col", 32'(in_col), 0);
        chk("rst_row", 32'(in_row), 0);
        rst = 1'b0;
        tick();

        // Kernel table vectors
        for (int i = 0; i < 4; i++) begin
            cfg(tbl[i].sel);
            start_frame(1'b0, 2'd0);
            chk($sformatf("k00_sel%0d", tbl[i].sel), 32'(kernel[0][0]), 32'(tbl[i].k00));
            chk($sformatf("k01_sel%0d", tbl[i].sel), 32'(kernel[0][1]), 32'(tbl[i].k01));
            chk($sformatf("k11_sel%0d", tbl[i].sel), 32'(kernel[1][1]), 32'(tbl[i].k11));
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_busy", 32'(busy), 0);
        end

        // Frame A: select in same cycle as start, mid-stream select write
        m_rand = 1'b1;
        h0 = m_hs;
        d0 = done_cnt;
        start_frame(1'b1, 2'd1);
        chk("a_centre", 32'(kernel[1][1]), 5);
        send_pixels(NP, 1'b1);
        s_valid = 1'b1;
        @(negedge clk);
        chk("s_ready_after_n", 32'(s_ready), 0);
        chk("f_x_valid_after_n", 32'(f_x_valid), 0);
        tick();
        s_valid = 1'b0;
        chk("a_centre_held", 32'(kernel[1][1]), 5);
        wait_done(h0, d0);
        chk("a_centre_after_done", 32'(kernel[1][1]), 5);

        // Next frame picks up the select written during frame A
        normal_frame(8);

        // Drain timeout
        flt_hold = 1'b1;
        d0 = done_cnt;
        start_frame(1'b0, 2'd0);
        send_pixels(NP, 1'b0);
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k == TO - 1) begin
                chk("to_error_early", 32'(error), 0);
                chk("to_busy_early", 32'(busy), 1);
            end
        end
        chk("to_error_set", 32'(error), 1);
        chk("to_idle", 32'(busy), 0);
        chk("to_no_done", 32'(done_cnt - d0), 0);
        flt_hold = 1'b0;
        flush_filter();
        chk("to_error_sticky", 32'(error), 1);
        normal_frame(8);
        chk("to_error_cleared", 32'(error), 0);

        // Abort after five inputs
        flt_hold = 1'b1;
        d0 = done_cnt;
        start_frame(1'b0, 2'd0);
        send_pixels(5, 1'b0);
        abort = 1'b1;
        tick();
        abort   = 1'b0;
        s_valid = 1'b1;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_col", 32'(in_col), 0);
        chk("ab_row", 32'(in_row), 0);
        @(negedge clk);
        chk("ab_s_ready", 32'(s_ready), 0);
        tick();
        s_valid = 1'b0;
        chk("ab_no_done", 32'(done_cnt - d0), 0);
        flt_hold = 1'b0;
        flush_filter();
        normal_frame(8);

        // Asynchronous reset in the middle of STREAM
        start_frame(1'b0, 2'd0);
        send_pixels(3, 1'b0);
        repeat (2) tick();
        s_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_s_ready", 32'(s_ready), 0);
        chk("mid_rst_f_x_valid", 32'(f_x_valid), 0);
        chk("mid_rst_f_y_ready", 32'(f_y_ready), 0);
        chk("mid_rst_m_valid", 32'(m_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_k11", 32'(kernel[1][1]), 1);
        chk("mid_rst_k01", 32'(kernel[0][1]), 1);
        chk("mid_rst_col", 32'(in_col), 0);
        s_valid = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        normal_frame(1);
        chk("post_rst_k01", 32'(kernel[0][1]), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_conv_frame_controller
`default_nettype wire
